// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART byte sender between NUM_REQ requesters.
// Each grant goes out as a two-byte frame: header (HEADER_BASE + index), then the latched payload.
module uart_tx_scheduler #(
   parameter int         NUM_REQ        = 2,
   parameter logic [7:0] HEADER_BASE    = 8'hA0,
   parameter int         ACCEPT_TIMEOUT = 4095
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [8*NUM_REQ-1:0]   req_data,
   output logic [NUM_REQ-1:0]     ack,
   output logic [1:0]             grant_id,
   output logic                   sched_busy,
   output logic                   tx_err,
   output logic                   tx_start,
   output logic [7:0]             tx_data,
   input  logic                   tx_busy
);

   localparam int CW = $clog2(ACCEPT_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_IDLE} state_e;

   state_e               state_q;
   logic [NUM_REQ-1:0]   ack_q;
   logic [1:0]           grant_q;
   logic [1:0]           rr_q;
   logic                 byte_idx_q;
   logic [7:0]           payload_q;
   logic [7:0]           tx_data_q;
   logic                 tx_start_q;
   logic                 busy_q;
   logic                 err_q;
   logic [CW-1:0]        cnt_q;

   logic [1:0]           win;
   logic                 win_vld;
   logic [7:0]           win_data;
   logic [1:0]           rr_next;

   // Lowest rotation distance from rr_q wins; loops unroll to constant indices.
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i] && ((int'(rr_q) + k == i) || (int'(rr_q) + k == i + NUM_REQ))) begin
               win     = 2'(i);
               win_vld = 1'b1;
            end
         end
      end
   end

   always_comb begin
      win_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (2'(i) == win) win_data = req_data[8*i +: 8];
      end
   end

   assign rr_next = (grant_q == 2'(NUM_REQ - 1)) ? 2'd0 : grant_q + 2'd1;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         ack_q      <= '0;
         grant_q    <= '0;
         rr_q       <= '0;
         byte_idx_q <= 1'b0;
         payload_q  <= '0;
         tx_data_q  <= 8'hFF;
         tx_start_q <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
         cnt_q      <= '0;
      end else begin
         ack_q      <= '0;
         tx_start_q <= 1'b0;
         err_q      <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (win_vld) begin
                  grant_q    <= win;
                  payload_q  <= win_data;
                  byte_idx_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= START;
               end
            end
            START: begin
               tx_data_q  <= byte_idx_q ? payload_q : HEADER_BASE + {6'd0, grant_q};
               tx_start_q <= 1'b1;
               cnt_q      <= '0;
               state_q    <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (tx_busy) begin
                  state_q <= WAIT_IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
                  if ({1'b0, cnt_q} + 1 == ACCEPT_TIMEOUT) begin
                     err_q   <= 1'b1;
                     rr_q    <= rr_next;
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end
               end
            end
            WAIT_IDLE: begin
               if (!tx_busy) begin
                  if (!byte_idx_q) begin
                     byte_idx_q <= 1'b1;
                     state_q    <= START;
                  end else begin
                     ack_q   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;
                     rr_q    <= rr_next;
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ack        = ack_q;
   assign grant_id   = grant_q;
   assign sched_busy = busy_q;
   assign tx_err     = err_q;
   assign tx_start   = tx_start_q;
   assign tx_data    = tx_data_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: sender model plus a frame-level round-robin reference model.
module tb_uart_tx_scheduler;

   localparam int         NR = 3;
   localparam logic [7:0] HB = 8'hA0;

   logic              clock = 1'b0;
   logic              reset_n;
   logic [NR-1:0]     req;
   logic [8*NR-1:0]   req_data;
   logic [NR-1:0]     ack;
   logic [1:0]        grant_id;
   logic              sched_busy, tx_err, tx_start;
   logic [7:0]        tx_data;
   logic              tx_busy = 1'b0;

   logic [1:0]        req1;
   logic [15:0]       data1;
   logic [1:0]        ack1, gid1;
   logic              sb1, err1, ts1;
   logic [7:0]        td1;
   logic              busy1 = 1'b0;

   always #5 clock = ~clock;

   uart_tx_scheduler #(.NUM_REQ(NR), .HEADER_BASE(HB), .ACCEPT_TIMEOUT(15)) dut (
      .clock(clock), .reset_n(reset_n), .req(req), .req_data(req_data), .ack(ack),
      .grant_id(grant_id), .sched_busy(sched_busy), .tx_err(tx_err), .tx_start(tx_start),
      .tx_data(tx_data), .tx_busy(tx_busy));

   uart_tx_scheduler #(.NUM_REQ(2), .HEADER_BASE(8'hFF), .ACCEPT_TIMEOUT(15)) dut_wrap (
      .clock(clock), .reset_n(reset_n), .req(req1), .req_data(data1), .ack(ack1),
      .grant_id(gid1), .sched_busy(sb1), .tx_err(err1), .tx_start(ts1),
      .tx_data(td1), .tx_busy(busy1));

   int n_chk = 0, n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Sender model: optional 0..3 clock accept delay, then busy for 1..20 clocks.
   int         busy_cnt = 0, dly_cnt = 0, viol = 0, cyc = 0, ack_cnt = 0, st_cnt = 0;
   bit         snd_en = 1'b1, snd_rand = 1'b0;
   logic [7:0] held = '0;

   function automatic int blen();
      return snd_rand ? int'($urandom_range(1, 20)) : 20;
   endfunction

   always @(posedge clock) begin
      cyc++;
      if (|ack) ack_cnt++;
      if (tx_start) st_cnt++;
      if (reset_n && tx_start && tx_busy) viol++;
      if (reset_n && tx_busy && tx_data !== held) viol++;
      if (dly_cnt > 0) begin
         dly_cnt--;
         if (dly_cnt == 0) begin tx_busy <= 1'b1; busy_cnt = blen(); end
      end else if (busy_cnt > 0) begin
         busy_cnt--;
         if (busy_cnt == 0) tx_busy <= 1'b0;
      end else if (tx_start && snd_en) begin
         held = tx_data;
         dly_cnt = snd_rand ? int'($urandom_range(0, 3)) : 0;
         if (dly_cnt == 0) begin tx_busy <= 1'b1; busy_cnt = blen(); end
      end
   end

   // Reference model state: pending requesters, rr pointer, payload captured at grant.
   logic [NR-1:0] pend;
   int            rr_m;
   logic [7:0]    dat_m [NR];

   task automatic wait_for(input int which, input int lim, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < lim && !ok; c++) begin
         @(negedge clock);
         case (which)
            0:       ok = (tx_start === 1'b1);
            1:       ok = (|ack === 1'b1);
            default: ok = (tx_err === 1'b1);
         endcase
      end
      if (!ok) chk($sformatf("wait%0d_timeout", which), 32'd0, 32'd1);
   endtask

   // mode 0: winner drops req at ack; 1: all hold; 2: all drop. chg rewrites winner data mid-frame.
   task automatic run_frame(input int mode, input bit chg, input logic [7:0] nd);
      int w; bit ok; logic [7:0] h;
      w = -1;
      for (int k = 0; k < NR; k++)
         if (w < 0 && pend[(rr_m + k) % NR]) w = (rr_m + k) % NR;
      if (w < 0) begin chk("model_empty", 32'd0, 32'd1); return; end
      h = HB + 8'(w);
      wait_for(0, 60, ok);
      if (!ok) begin pend = '0; req = '0; return; end
      chk("hdr", tx_data, h);
      chk("gnt", grant_id, w);
      chk("sbusy", sched_busy, 1);
      if (chg) req_data[8*w +: 8] = nd;
      wait_for(0, 60, ok);
      if (!ok) begin pend = '0; req = '0; return; end
      chk("payload", tx_data, dat_m[w]);
      wait_for(1, 60, ok);
      if (!ok) begin pend = '0; req = '0; return; end
      chk("ack", ack, 32'd1 << w);
      chk("sbusy_ack", sched_busy, 0);
      chk("err_ack", tx_err, 0);
      if (mode == 0) begin req[w] = 1'b0; pend[w] = 1'b0; end
      if (mode == 2) begin req = '0; pend = '0; end
      rr_m = (w + 1) % NR;
      @(negedge clock);
      chk("ack_pulse", ack, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      bit ok; int t0, a0, s0, guard;
      reset_n = 1'b0; req = '0; req_data = '0; req1 = '0; data1 = '0;
      pend = '0; rr_m = 0;
      for (int i = 0; i < NR; i++) dat_m[i] = '0;
      repeat (3) @(negedge clock);
      chk("rst_out", {tx_data, tx_start, ack, grant_id, sched_busy, tx_err},
          {8'hFF, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0});
      reset_n = 1'b1;

      // header wrap on the second instance
      req1 = 2'b10; data1 = 16'h3C00;
      ok = 1'b0;
      for (int c = 0; c < 10 && !ok; c++) begin @(negedge clock); ok = (ts1 === 1'b1); end
      chk("wrap_seen", ok, 1);
      chk("wrap_hdr", td1, 8'h00);
      chk("wrap_gnt", gid1, 1);
      req1 = '0;

      // single request, fixed 20-clock bytes
      req_data[7:0] = 8'h5C; dat_m[0] = 8'h5C; req = 3'b001; pend = 3'b001;
      s0 = st_cnt;
      run_frame(0, 1'b0, 8'h00);
      chk("starts", st_cnt - s0, 2);
      @(negedge clock);
      chk("idle_after", sched_busy, 0);

      // contention, requests held throughout
      req_data[15:0] = 16'h2211; dat_m[0] = 8'h11; dat_m[1] = 8'h22;
      req = 3'b011; pend = 3'b011;
      for (int f = 0; f < 4; f++) run_frame((f == 3) ? 2 : 1, 1'b0, 8'h00);

      // payload change while header is on the line
      repeat (2) @(negedge clock);
      req_data[7:0] = 8'h33; dat_m[0] = 8'h33; req = 3'b001; pend = 3'b001;
      run_frame(0, 1'b1, 8'h44);

      // accept timeout from a known rr pointer
      @(negedge clock); reset_n = 1'b0; @(negedge clock); reset_n = 1'b1; rr_m = 0;
      snd_en = 1'b0;
      req_data[15:0] = 16'h6655; dat_m[0] = 8'h55; dat_m[1] = 8'h66;
      req = 3'b011; pend = 3'b011;
      wait_for(0, 20, ok);
      chk("to_hdr", tx_data, 8'hA0);
      t0 = cyc; a0 = ack_cnt;
      wait_for(2, 40, ok);
      chk("to_lat", cyc - t0, 15);
      chk("to_noack", ack_cnt, a0);
      chk("to_sbusy", sched_busy, 0);
      rr_m = 1; snd_en = 1'b1;
      run_frame(0, 1'b0, 8'h00);
      run_frame(0, 1'b0, 8'h00);

      // reset during payload byte
      req_data[7:0] = 8'h77; dat_m[0] = 8'h77; req = 3'b001; pend = 3'b001;
      wait_for(0, 60, ok);
      wait_for(0, 60, ok);
      repeat (3) @(negedge clock);
      a0 = ack_cnt;
      reset_n = 1'b0;
      #1;
      chk("midrst_out", {tx_data, tx_start, ack, grant_id, sched_busy, tx_err},
          {8'hFF, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0});
      req = '0; pend = '0;
      ok = 1'b0;
      for (int c = 0; c < 40 && !ok; c++) begin @(negedge clock); ok = (tx_busy === 1'b0); end
      chk("midrst_noack", ack_cnt, a0);
      req_data[15:8] = 8'h88; dat_m[1] = 8'h88; req = 3'b010; pend = 3'b010; rr_m = 0;
      @(negedge clock); reset_n = 1'b1;
      run_frame(0, 1'b0, 8'h00);

      // randomized rounds with random byte timing and mid-frame data scrambling
      snd_rand = 1'b1;
      for (int r = 0; r < 25; r++) begin
         repeat ($urandom_range(0, 3)) @(negedge clock);
         for (int i = 0; i < NR; i++) begin
            dat_m[i] = 8'($urandom);
            req_data[8*i +: 8] = dat_m[i];
         end
         pend = NR'($urandom_range(1, (1 << NR) - 1));
         req = pend;
         guard = 0;
         while (pend != '0 && guard < NR + 1) begin
            run_frame(0, 1'b1, 8'($urandom));
            guard++;
         end
      end

      repeat (30) @(negedge clock);
      chk("protocol", viol, 0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
